countone_deadlock_reporter: RTL and testbench

//  Consumer side of the deadlock-monitor block signals. Takes the 1-bit "block" outputs of NUM_MON

---
 rtl/countone_deadlock_pkg.sv | 16 +
 rtl/countone_deadlock_persist.sv | 31 +++
 rtl/countone_deadlock_reporter.sv | 118 +++++++++++
 tb/tb_countone_deadlock_reporter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countone_deadlock_pkg.sv
// Shared types and constants for the deadlock reporter.
// Report FSM encoding and report header constants.
package countone_deadlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_MASK = 3'd2,
        ST_TS   = 3'd3,
        ST_HELD = 3'd4
    } state_t;

    localparam logic [15:0] REPORT_MAGIC = 16'hDEAD;
    localparam int          REPORT_WORDS = 3;

endpackage

// File: rtl/countone_deadlock_persist.sv
// Saturating persistence counter for one monitor block input.
// conf is high once block has been seen for THRESHOLD consecutive cycles.
module countone_deadlock_persist #(
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic block,
    input  logic enable,
    input  logic flush,
    output logic conf
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!block || !enable || flush) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign conf = (cnt == LIMIT);

endmodule

// File: rtl/countone_deadlock_reporter.sv
// Confirms persistent monitor blocks and streams a 3-word report.
// Holds a sticky deadlock flag until software clears it.
module countone_deadlock_reporter
    import countone_deadlock_pkg::*;
#(
    parameter int NUM_MON   = 2,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               enable,
    input  logic               clear,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [31:0]        m_tdata,
    output logic               m_tlast,
    output logic               deadlock,
    output logic [7:0]         first_idx
);

    localparam logic [7:0] NUM_MON_B = 8'(NUM_MON);

    state_t             state;
    logic [NUM_MON-1:0] conf;
    logic               flush;
    logic [7:0]         low_idx;
    logic [31:0]        timestamp;
    logic [31:0]        ts_q;
    logic [31:0]        mask_q;

    // Re-arming zeroes every counter so a report needs a fresh full run.
    assign flush = (state == ST_HELD) && clear;

    for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
        countone_deadlock_persist #(
            .THRESHOLD (THRESHOLD),
            .CNT_W     (CNT_W)
        ) u_persist (
            .clock   (clock),
            .reset_n (reset_n),
            .block   (block_sigs[g]),
            .enable  (enable),
            .flush   (flush),
            .conf    (conf[g])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (conf[i]) low_idx = 8'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) timestamp <= '0;
        else          timestamp <= timestamp + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            deadlock  <= 1'b0;
            first_idx <= '0;
            ts_q      <= '0;
            mask_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable && |conf) begin
                        state     <= ST_HDR;
                        mask_q    <= 32'(conf);
                        ts_q      <= timestamp;
                        m_tvalid  <= 1'b1;
                        m_tdata   <= {REPORT_MAGIC, low_idx, NUM_MON_B};
                        deadlock  <= 1'b1;
                        first_idx <= low_idx;
                    end
                end
                ST_HDR: begin
                    if (m_tready) begin
                        state   <= ST_MASK;
                        m_tdata <= mask_q;
                    end
                end
                ST_MASK: begin
                    if (m_tready) begin
                        state   <= ST_TS;
                        m_tdata <= ts_q;
                        m_tlast <= 1'b1;
                    end
                end
                ST_TS: begin
                    if (m_tready) begin
                        state    <= ST_HELD;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        m_tdata  <= '0;
                    end
                end
                ST_HELD: begin
                    if (clear) begin
                        state     <= ST_IDLE;
                        deadlock  <= 1'b0;
                        first_idx <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countone_deadlock_reporter.sv
// Scoreboard bench for countone_deadlock_reporter.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_countone_deadlock_reporter;

    localparam int NUM_MON = 2;
    localparam int TH      = 16;

    logic               clock;
    logic               reset_n;
    logic [NUM_MON-1:0] block_sigs;
    logic               enable;
    logic               clear;
    logic               m_tready;
    logic               m_tvalid;
    logic [31:0]        m_tdata;
    logic               m_tlast;
    logic               deadlock;
    logic [7:0]         first_idx;

    countone_deadlock_reporter #(
        .NUM_MON   (NUM_MON),
        .THRESHOLD (TH),
        .CNT_W     (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .block_sigs (block_sigs),
        .enable     (enable),
        .clear      (clear),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .deadlock   (deadlock),
        .first_idx  (first_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: run lengths per monitor, report phase, words left.
    int          run [NUM_MON];
    int          phase;
    int          left;
    bit          m_dl;
    int          m_idx;
    logic [31:0] ts_m;
    bit          m_flush;
    int          m_cmask;
    int          m_first;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MON; i++) run[i] <= 0;
            phase <= 0;
            left  <= 0;
            m_dl  <= 1'b0;
            m_idx <= 0;
            ts_m  <= '0;
            exp_q.delete();
        end else begin
            m_flush = (phase == 2) && clear;
            m_cmask = 0;
            m_first = -1;
            for (int i = 0; i < NUM_MON; i++) begin
                if (run[i] >= TH) begin
                    m_cmask = m_cmask | (1 << i);
                    if (m_first < 0) m_first = i;
                end
            end
            case (phase)
                0: if (enable && m_cmask != 0) begin
                    exp_q.push_back('{data: {16'hDEAD, 8'(m_first), 8'(NUM_MON)},
                                      last: 1'b0});
                    exp_q.push_back('{data: 32'(m_cmask), last: 1'b0});
                    exp_q.push_back('{data: ts_m, last: 1'b1});
                    phase <= 1;
                    left  <= 3;
                    m_dl  <= 1'b1;
                    m_idx <= m_first;
                end
                1: if (m_tready) begin
                    left  <= left - 1;
                    phase <= (left == 1) ? 2 : 1;
                end
                2: if (clear) begin
                    phase <= 0;
                    m_dl  <= 1'b0;
                    m_idx <= 0;
                end
                default: phase <= 0;
            endcase
            for (int i = 0; i < NUM_MON; i++) begin
                if (block_sigs[i] && enable && !m_flush)
                    run[i] <= (run[i] < TH) ? run[i] + 1 : TH;
                else
                    run[i] <= 0;
            end
            ts_m <= ts_m + 32'd1;
        end
    end

    // Monitor: compare flags every cycle, pop a word on each handshake.
    bit          prev_stall;
    logic [31:0] prev_data;
    word_t       got;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("tvalid", 32'(m_tvalid), 32'(phase == 1));
            chk("deadlock", 32'(deadlock), 32'(m_dl));
            chk("first_idx", 32'(first_idx), m_idx[31:0]);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_tdata, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    chk("tdata", m_tdata, got.data);
                    chk("tlast", 32'(m_tlast), 32'(got.last));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_hdr(input string nm, input int want);
        int e;
        e = 0;
        while (!m_tvalid && e < 60) begin
            cyc(1);
            e++;
        end
        chk(nm, e, want);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        block_sigs = '0;
        enable     = 1'b0;
        clear      = 1'b0;
        m_tready   = 1'b0;
        cyc(2);
        chk("reset_tvalid", 32'(m_tvalid), 32'd0);
        chk("reset_deadlock", 32'(deadlock), 32'd0);

        // 1: single monitor, ready tied high
        reset_n    = 1'b1;
        block_sigs = 2'b10;
        enable     = 1'b1;
        m_tready   = 1'b1;
        wait_hdr("t1_hdr_cycle", 17);
        chk("t1_deadlock", 32'(deadlock), 32'd1);
        chk("t1_first_idx", 32'(first_idx), 32'd1);
        cyc(3);
        pulse_clear();
        block_sigs = '0;
        chk("t1_cleared", 32'(deadlock), 32'd0);

        // 2: one-cycle gap restarts the count
        block_sigs = 2'b01;
        cyc(15);
        block_sigs = 2'b00;
        cyc(1);
        block_sigs = 2'b01;
        cyc(15);
        block_sigs = 2'b00;
        cyc(20);
        chk("t2_no_deadlock", 32'(deadlock), 32'd0);

        // 3: simultaneous confirm, backpressure in HDR
        m_tready   = 1'b0;
        block_sigs = 2'b11;
        wait_hdr("t3_hdr_cycle", 17);
        chk("t3_first_idx", 32'(first_idx), 32'd0);
        cyc(5);
        chk("t3_stalled_data", m_tdata, 32'hDEAD_0002);
        m_tready = 1'b1;
        cyc(3);

        // 4: clear ignored in MASK, honoured in HELD
        pulse_clear();
        chk("t4_cleared", 32'(deadlock), 32'd0);
        wait_hdr("t4_rearm_cycle", 17);
        cyc(1);
        pulse_clear();
        cyc(1);
        chk("t4_held_deadlock", 32'(deadlock), 32'd1);
        chk("t4_held_tvalid", 32'(m_tvalid), 32'd0);
        pulse_clear();
        block_sigs = 2'b00;

        // 5: reset in the middle of TS
        block_sigs = 2'b01;
        wait_hdr("t5_hdr_cycle", 17);
        cyc(2);
        chk("t5_in_ts", 32'(m_tlast), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_deadlock", 32'(deadlock), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        wait_hdr("t5_fresh_cycle", 17);
        cyc(3);
        pulse_clear();
        block_sigs = 2'b00;

        // 6: enable gates detection
        enable     = 1'b0;
        block_sigs = 2'b11;
        cyc(100);
        chk("t6_no_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_no_deadlock", 32'(deadlock), 32'd0);
        enable = 1'b1;
        wait_hdr("t6_hdr_cycle", 17);
        cyc(3);
        pulse_clear();
        block_sigs = 2'b00;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_MON; i++)
                if ($urandom_range(19) == 0) block_sigs[i] = ~block_sigs[i];
            enable   = ($urandom_range(49) != 0);
            m_tready = ($urandom_range(3) != 0);
            clear    = ($urandom_range(7) == 0);
            cyc(1);
        end

        block_sigs = '0;
        clear      = 1'b0;
        m_tready   = 1'b1;
        cyc(5);
        pulse_clear();
        cyc(3);
        chk("drain_queue", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
